int_div_arbiter: RTL
====================

Name: int_div_arbiter

Overview:
- Controller that shares one multi-cycle integer divide/remainder unit between two requesters, e.g. an integer issue slot and a secondary issue slot/microcode sequencer.
- Accepts one operation at a time, issues it to the divider with a start pulse, and waits for the done pulse.
- Buffers the result and returns it to the owning requester over a valid/ready response channel.
- Exports the destination register currently in flight for hazard detection.

Parameters:
WIDTH  32  operand/result width in bits
TIMEOUT  64  max cycles in WAIT before the watchdog aborts the operation
CNT_W  16  width of the saturating per-requester issue counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
clear  in  1  pipeline flush; aborts any in-flight operation
req_valid  in  2  request valid, bit n = requester n
req_ready  out  2  request accepted (one-hot or zero)
req_op  in  2x2  per requester: 00 DIV, 01 DIVU, 10 REM, 11 REMU
req_a  in  2xWIDTH  dividend per requester
req_b  in  2xWIDTH  divisor per requester
req_rd  in  2x5  destination register per requester
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed
rsp_id  out  1  requester owning the response
rsp_data  out  WIDTH  quotient/remainder
rsp_rd  out  5  destination register
rsp_dbz  out  1  divide-by-zero flag
rsp_ovf  out  1  overflow flag (INT_MIN / -1)
rsp_err  out  1  watchdog timeout; rsp_data forced to 0
div_start  out  1  one-cycle start pulse to divider
div_op  out  2  latched op
div_a  out  WIDTH  latched dividend
div_b  out  WIDTH  latched divisor
div_rd  out  5  latched rd
div_clear  out  1  one-cycle clear to divider
div_done  in  1  divider completion pulse
div_result  in  WIDTH  divider result
div_dbz  in  1  divider dbz flag
div_ovf  in  1  divider ovf flag
busy  out  1  high in every state except IDLE
busy_rd  out  5  rd in flight; 0 when IDLE
issue_cnt  out  2xCNT_W  saturating count of accepted requests per requester

Behaviour:
- Clocking: all state on posedge clk. rst is synchronous and active-high.
- Reset values: state=IDLE; all outputs 0; issue_cnt=0; RR pointer last_grant=1.
- FSM IDLE:
  - req_ready is asserted combinationally for the granted requester only when state=IDLE and that requester's req_valid=1.
  - On the handshake: latch op/a/b/rd/id, increment that issue_cnt (saturating at all-ones), go to ISSUE.
  - With no req_valid, stay in IDLE.
- FSM ISSUE: div_start=1 for exactly this cycle; div_op/a/b/rd hold the latched values; go to WAIT; clear the watchdog counter.
- FSM WAIT:
  - On div_done: capture div_result/dbz/ovf into the response registers and go to RESP.
  - div_done may arrive as early as the cycle after ISSUE; special cases return fast.
  - Watchdog: the counter increments each WAIT cycle. If it reaches TIMEOUT-1 without div_done, pulse div_clear, set rsp_err=1 and rsp_data=0, go to RESP.
- FSM RESP:
  - rsp_valid=1; rsp_* stable until rsp_ready.
  - On rsp_valid&&rsp_ready, go to IDLE. A new request may be accepted the cycle after, never in the same cycle.
- Latency: minimum 4 cycles from request handshake to rsp_valid (accept, ISSUE, WAIT with done, RESP).
- Arbitration: grant is fixed or round-robin, per the Optional Feature section.
- clear:
  - In ISSUE/WAIT/RESP: go to IDLE next cycle, drop the response, pulse div_clear if in ISSUE or WAIT, deassert rsp_valid. No req_ready in the clear cycle.
  - In IDLE: no effect except suppressing req_ready that cycle.
- Priority: rst > clear > normal.
- div_done while not in WAIT is ignored.
- rst mid-operation returns to IDLE with no div_clear pulse; the divider is reset by the same rst.
- busy_rd = latched rd in ISSUE/WAIT/RESP, else 0.

Optional Feature:
- Macro: INT_DIV_ARB_RR_EN.
- Defined: round-robin arbitration.
  - When both requesters are valid, grant the one not equal to last_grant.
  - last_grant updates on each handshake.
  - The first grant after reset goes to requester 0.
- Undefined: fixed priority; requester 0 always wins. last_grant logic is absent.

Test Plan:
- Req0 DIV a=100 b=7 rd=5, div_done 32 cycles after start with result 14 -> rsp_valid, rsp_id=0, rsp_data=14, rsp_rd=5, busy_rd=5 throughout, issue_cnt[0]=1.
- Both valid (req0 REM 100,7; req1 DIVU 9,3), RR enabled -> req0 served first (data 2), then req1 (data 3); with the macro undefined and req0 held valid, req1 is never granted.
- Divider returns done 1 cycle after start with dbz=1, result 0xFFFFFFFF -> rsp_dbz=1, rsp_data=0xFFFFFFFF; rsp_ready held low 5 cycles -> response stable, req_ready=0.
- div_done never arrives, TIMEOUT=64 -> div_clear pulse 64 cycles after ISSUE, rsp_err=1, rsp_data=0.
- clear asserted in WAIT -> div_clear pulse, IDLE next cycle, no rsp_valid; a later div_done is ignored.
- issue_cnt preloaded near saturation via 2^CNT_W accepted requests -> stays 0xFFFF.

Source files
------------

// File: rtl/int_div_arbiter.sv
// int_div_arbiter
//   Shares one multi-cycle integer divide/remainder unit between two requesters.
//   One operation is in flight at a time: accept -> ISSUE (div_start) -> WAIT
//   (div_done or watchdog) -> RESP (valid/ready) -> IDLE.
//
// Ports
//   clk, rst, clear           : clock, synchronous active-high reset, pipeline flush
//   req_valid/req_ready       : per-requester handshake (bit n = requester n)
//   req_op/req_a/req_b/req_rd : per-requester operands, packed {req1, req0}
//   rsp_*                     : buffered response to the owning requester
//   div_*                     : divider start/clear, latched operands, done/result/flags
//   busy, busy_rd             : occupancy and destination register in flight
//   issue_cnt                 : saturating accept counters, packed {req1, req0}
//
// Build option
//   INT_DIV_ARB_RR_EN defined  : round-robin arbitration between the two requesters.
//   INT_DIV_ARB_RR_EN undefined: fixed priority, requester 0 always wins.

module int_div_arbiter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [3:0]           req_op,
    input  logic [2*WIDTH-1:0]   req_a,
    input  logic [2*WIDTH-1:0]   req_b,
    input  logic [9:0]           req_rd,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [WIDTH-1:0]     rsp_data,
    output logic [4:0]           rsp_rd,
    output logic                 rsp_dbz,
    output logic                 rsp_ovf,
    output logic                 rsp_err,
    output logic                 div_start,
    output logic [1:0]           div_op,
    output logic [WIDTH-1:0]     div_a,
    output logic [WIDTH-1:0]     div_b,
    output logic [4:0]           div_rd,
    output logic                 div_clear,
    input  logic                 div_done,
    input  logic [WIDTH-1:0]     div_result,
    input  logic                 div_dbz,
    input  logic                 div_ovf,
    output logic                 busy,
    output logic [4:0]           busy_rd,
    output logic [2*CNT_W-1:0]   issue_cnt
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    localparam int unsigned    WdW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [4:0]         rd_q, rd_d;
    logic               id_q, id_d;
    logic [WdW-1:0]     wd_q, wd_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               dbz_q, dbz_d, ovf_q, ovf_d, err_q, err_d;
    logic [CNT_W-1:0]   cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic               gnt;

`ifdef INT_DIV_ARB_RR_EN
    logic last_grant_q, last_grant_d;
    // Contention goes to whoever did not win last; reset value 1 favours requester 0.
    always_comb gnt = (&req_valid) ? ~last_grant_q : req_valid[1];
`else
    always_comb gnt = ~req_valid[0];
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        rd_d      = rd_q;
        id_d      = id_q;
        wd_d      = wd_q;
        data_d    = data_q;
        dbz_d     = dbz_q;
        ovf_d     = ovf_q;
        err_d     = err_q;
        cnt0_d    = cnt0_q;
        cnt1_d    = cnt1_q;
`ifdef INT_DIV_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        req_ready = 2'b00;
        div_start = 1'b0;
        div_clear = 1'b0;

        if (clear) begin
            // Flush: drop whatever is in flight; only an active divider needs clearing.
            div_clear = (state_q == StIssue) || (state_q == StWait);
            state_d   = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|req_valid) begin
                        req_ready = gnt ? 2'b10 : 2'b01;
                        op_d      = gnt ? req_op[3:2] : req_op[1:0];
                        a_d       = gnt ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
                        b_d       = gnt ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
                        rd_d      = gnt ? req_rd[9:5] : req_rd[4:0];
                        id_d      = gnt;
                        if (gnt) begin
                            if (cnt1_q != '1) cnt1_d = cnt1_q + 1'b1;
                        end else begin
                            if (cnt0_q != '1) cnt0_d = cnt0_q + 1'b1;
                        end
`ifdef INT_DIV_ARB_RR_EN
                        last_grant_d = gnt;
`endif
                        state_d   = StIssue;
                    end
                end
                StIssue: begin
                    div_start = 1'b1;
                    wd_d      = '0;
                    state_d   = StWait;
                end
                StWait: begin
                    // A real completion beats a watchdog expiring in the same cycle.
                    if (div_done) begin
                        data_d  = div_result;
                        dbz_d   = div_dbz;
                        ovf_d   = div_ovf;
                        err_d   = 1'b0;
                        state_d = StResp;
                    end else if (wd_q == WdLast) begin
                        div_clear = 1'b1;
                        data_d    = '0;
                        dbz_d     = 1'b0;
                        ovf_d     = 1'b0;
                        err_d     = 1'b1;
                        state_d   = StResp;
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
                end
                StResp: begin
                    if (rsp_ready) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end

        // The divider shares this reset, so no pulses go out while it is asserted.
        if (rst) begin
            req_ready = 2'b00;
            div_start = 1'b0;
            div_clear = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            id_q    <= 1'b0;
            wd_q    <= '0;
            data_q  <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
`ifdef INT_DIV_ARB_RR_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rd_q    <= rd_d;
            id_q    <= id_d;
            wd_q    <= wd_d;
            data_q  <= data_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
`ifdef INT_DIV_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    always_comb begin
        busy      = (state_q != StIdle);
        busy_rd   = busy ? rd_q : 5'd0;
        rsp_valid = (state_q == StResp);
        rsp_id    = id_q;
        rsp_data  = data_q;
        rsp_rd    = rd_q;
        rsp_dbz   = dbz_q;
        rsp_ovf   = ovf_q;
        rsp_err   = err_q;
        div_op    = op_q;
        div_a     = a_q;
        div_b     = b_q;
        div_rd    = rd_q;
        issue_cnt = {cnt1_q, cnt0_q};
    end

endmodule
